// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces start/stop/clear/lap, runs the run/pause/lap FSM and
// produces single-cycle count-enable and clear pulses for the 00-99 counter.
module stopwatch_ctrl #(
    parameter int CLK_HZ     = 5000000,
    parameter int TICK_HZ    = 1,
    parameter int DEB_CYCLES = 50000,
    parameter bit AUTO_STOP  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    input  logic       cnt_max,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = $clog2(DEB_CYCLES);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    // Button lanes; a lower index wins when several events coincide.
    localparam int B_CLEAR = 0;
    localparam int B_STOP  = 1;
    localparam int B_START = 2;
    localparam int B_LAP   = 3;
    localparam int NB      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLEAR,
        EV_STOP,
        EV_START,
        EV_LAP
    } ev_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] s1;
    logic [NB-1:0] s2;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_d;
    logic [NB-1:0] press;
    logic [DW-1:0] deb_cnt [NB];

    state_t        st;
    state_t        st_nx;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nx;
    logic          en_nx;
    logic          clr_nx;
    logic          running;
    logic          tick;
    ev_t           ev;

    assign raw = {lap, start, stop, clear};

    // NOTE: every register in a clocked block is assigned with <= so all
    // flops sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < NB; i++) begin
                if (s2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb[i]     <= s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign press   = deb & ~deb_d;
    assign running = (st == RUN) || (st == LAP);
    assign tick    = running && (pre == PRE_MAX);

    always_comb begin
        ev = EV_NONE;
        if (press[B_CLEAR]) begin
            ev = EV_CLEAR;
        end else if (press[B_STOP]) begin
            ev = EV_STOP;
        end else if (press[B_START]) begin
            ev = EV_START;
        end else if (press[B_LAP]) begin
            ev = EV_LAP;
        end
    end

    // NOTE: defaults are assigned first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        st_nx  = st;
        pre_nx = pre;
        en_nx  = 1'b0;
        clr_nx = 1'b0;

        if (running) begin
            pre_nx = (pre == PRE_MAX) ? '0 : pre + PW'(1);
        end

        unique case (ev)
            EV_CLEAR: begin
                st_nx  = IDLE;
                clr_nx = 1'b1;
            end
            EV_STOP: begin
                if (running) st_nx = PAUSE;
            end
            EV_START: begin
                // From PAUSE the prescaler is untouched, keeping the fraction.
                if (st == IDLE || st == PAUSE) st_nx = RUN;
            end
            EV_LAP: begin
                if (st == RUN) begin
                    st_nx = LAP;
                end else if (st == LAP) begin
                    st_nx = RUN;
                end
            end
            default: begin
            end
        endcase

        // A clear in the same cycle wins: the counter sees the clear only.
        if (tick && ev != EV_CLEAR) begin
            if (AUTO_STOP && cnt_max) begin
                st_nx = PAUSE;
            end else begin
                en_nx = 1'b1;
            end
        end

        if (st_nx == IDLE) pre_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            pre       <= '0;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
            disp_hold <= 1'b0;
        end else begin
            st        <= st_nx;
            pre       <= pre_nx;
            cnt_en    <= en_nx;
            cnt_clr   <= clr_nx;
            disp_hold <= (st == LAP);
        end
    end

    assign state = st;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control block for the two-digit 00-99 stopwatch counter and its BCD 7-segment display path. It debounces the start, stop, clear and lap buttons and runs the run/pause/lap state machine. Instead of a divided clock, it produces a single-cycle count-enable tick in the system clock domain. The counter and seg drivers run on clk and take cnt_en, cnt_clr and disp_hold from this block.

Parameters:
CLK_HZ, 5000000, system clock frequency.
TICK_HZ, 1, count rate. DIV = CLK_HZ/TICK_HZ, integer, at least 2.
DEB_CYCLES, 50000, consecutive stable cycles needed to accept a button level (at least 2).
AUTO_STOP, 0. When 1, counting stops at 99 instead of wrapping.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  raw button, asynchronous, active-high
stop  in  1  raw button, asynchronous, active-high
clear  in  1  raw button, asynchronous, active-high
lap  in  1  raw button, asynchronous, active-high
cnt_max  in  1  counter reports value 99
cnt_en  out  1  one-cycle count pulse to counter
cnt_clr  out  1  one-cycle counter clear
disp_hold  out  1  freeze displayed value (lap)
state  out  2  IDLE=00, RUN=01, PAUSE=10, LAP=11

Behaviour:
- Reset: rst is synchronous and active-high; all logic is clocked on clk. While rst is high at a clock edge, the following are set:
  - state=IDLE; cnt_en=0, cnt_clr=0, disp_hold=0;
  - prescaler=0; all synchronizers, debounced levels and debounce counters =0.
  - Reset mid-operation discards any pending press or tick.
- Button path, per button, identical:
  - 2-FF synchronizer s1/s2.
  - Debounce counter increments while s2 != deb. It clears whenever s2 == deb.
  - When the counter is at DEB_CYCLES-1 and s2 != deb: deb<=s2 and the counter clears.
  - Press event = deb & ~deb_d, one cycle wide.
  - Timing: if raw is first sampled high at edge k, deb rises at edge k+1+DEB_CYCLES and the FSM acts at edge k+2+DEB_CYCLES.
  - A glitch shorter than DEB_CYCLES cycles produces no event. Release produces no event. Holding a button produces exactly one event.
- Event priority in the same cycle: clear > stop > start > lap. Only the highest-priority event is acted on.
- FSM transitions:
  - IDLE: start -> RUN, prescaler=0. clear -> IDLE with cnt_clr. stop and lap are ignored.
  - RUN: clear -> IDLE with cnt_clr. stop -> PAUSE. lap -> LAP. start is ignored.
  - LAP: clear -> IDLE with cnt_clr. stop -> PAUSE. lap -> RUN. start is ignored.
  - PAUSE: clear -> IDLE with cnt_clr. start -> RUN, prescaler preserved (fractional second kept). stop and lap are ignored.
- Prescaler:
  - Counts 0..DIV-1 and wraps, in RUN and LAP only. It holds in PAUSE and is forced to 0 in IDLE.
  - tick = (prescaler==DIV-1) & state in {RUN, LAP}.
- Registered outputs, all updated at the edge following the condition:
  - cnt_en = 1 in the cycle after tick, unless AUTO_STOP=1 and cnt_max=1.
  - If AUTO_STOP=1 and tick occurs with cnt_max=1: no cnt_en, and the FSM goes to PAUSE at that same edge.
  - With AUTO_STOP=0, wrap 99->00 is the counter's job; cnt_en is issued normally.
  - cnt_clr = 1 for exactly one cycle after any clear event, including clear in IDLE.
  - disp_hold = 1 exactly while state==LAP, with one-cycle register delay.
- Simultaneous events:
  - tick and stop in the same cycle: the tick's cnt_en is still issued, then PAUSE.
  - tick and clear in the same cycle: cnt_en is suppressed and cnt_clr is issued. The counter sees clear only.
- Every clock edge with state RUN/LAP produces at most one cnt_en per DIV cycles. No cnt_en is ever issued in IDLE or PAUSE.

Test Plan:
(Benches use CLK_HZ=10, TICK_HZ=1 so DIV=10, and DEB_CYCLES=4.)
- Reset, then raw start high from edge 20 and held -> state=RUN at edge 26. cnt_en pulses at edges 36, 46, 56, one cycle each. A single start event despite the long hold.
- 2-cycle start glitch in IDLE -> no state change, no cnt_en.
- RUN, press stop at prescaler=6, wait 50 cycles, press start -> no cnt_en during PAUSE. First cnt_en arrives 4 cycles after return to RUN (fraction kept).
- RUN, press lap -> disp_hold=1 one cycle after LAP and cnt_en continues every 10 cycles. Press lap again -> disp_hold=0, state RUN.
- clear and start debounced in the same cycle while PAUSE -> state IDLE, one cnt_clr pulse, no cnt_en. clear coinciding with a tick in RUN -> cnt_clr only.
- AUTO_STOP=1, cnt_max tied 1 in RUN -> at the next tick, no cnt_en and state=PAUSE. With AUTO_STOP=0, same stimulus -> cnt_en issued and state stays RUN. Assert rst mid-RUN -> all outputs 0 and state IDLE after that edge.
